// File: rtl/alu_shl_result_stage.sv
// alu_shl_result_stage: DEPTH-entry result FIFO behind the shift-left ALU.
// Captures R/CF, derives ZF/NF at push time, and presents them over valid/ready.
// Ports: clk, rst (sync active-high); in_valid/in_r/in_cf/in_ready (shifter side);
// out_valid/out_r/out_cf/out_zf/out_nf/out_ready (consumer side); count (occupancy);
// clr_sticky/sticky_cf (accumulated carry).
// Optional feature: define ALU_SHL_RESULT_STICKY_CF_EN to enable sticky_cf; otherwise it reads 0.
module alu_shl_result_stage #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_r,
  input  logic                       in_cf,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_r,
  output logic                       out_cf,
  output logic                       out_zf,
  output logic                       out_nf,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       clr_sticky,
  output logic                       sticky_cf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = WIDTH + 3;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;
  logic [EW-1:0] w_head;
  assign in_ready  = r_count < CW'(DEPTH);
  assign out_valid = r_count != '0;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign count     = r_count;
  // Entry layout: {R, CF, ZF, NF}; flags are frozen at capture.
  assign w_head = r_mem[r_rd];
  assign out_r  = out_valid ? w_head[EW-1:3] : '0;
  assign out_cf = out_valid && w_head[2];
  assign out_zf = out_valid && w_head[1];
  assign out_nf = out_valid && w_head[0];
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {in_r, in_cf, in_r == '0, in_r[WIDTH-1]};
  end
  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= w_push ? r_wr + 1'b1 : r_wr;
      r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
      r_count <= (w_push && !w_pop) ? r_count + 1'b1 :
                 (w_pop && !w_push) ? r_count - 1'b1 : r_count;
    end
  end
`ifdef ALU_SHL_RESULT_STICKY_CF_EN
  logic r_sticky;
  // A carry captured on the same edge as a clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) r_sticky <= 1'b0;
    else     r_sticky <= (w_push && in_cf) ? 1'b1 : clr_sticky ? 1'b0 : r_sticky;
  end
  assign sticky_cf = r_sticky;
`else
  logic w_unused;
  assign w_unused  = clr_sticky;
  assign sticky_cf = 1'b0;
`endif
endmodule

// File: tb/tb_alu_shl_result_stage.sv
// tb_alu_shl_result_stage: directed self-checking bench for alu_shl_result_stage.
module tb_alu_shl_result_stage;
`ifdef ALU_SHL_RESULT_STICKY_CF_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif
  logic       clk = 0;
  logic       rst, in_valid, in_cf, in_ready, out_valid, out_cf, out_zf, out_nf;
  logic       out_ready, clr_sticky, sticky_cf;
  logic [4:0] in_r, out_r;
  logic [1:0] count;
  int         n_chk = 0, n_err = 0;
  alu_shl_result_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_cf(in_cf),
    .in_ready(in_ready), .out_valid(out_valid), .out_r(out_r), .out_cf(out_cf),
    .out_zf(out_zf), .out_nf(out_nf), .out_ready(out_ready), .count(count),
    .clr_sticky(clr_sticky), .sticky_cf(sticky_cf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic head(input string tag, input logic [4:0] r, input logic cf, zf, nf);
    chk({tag, "_v"}, 32'(out_valid), 1);
    chk({tag, "_r"}, 32'(out_r), 32'(r));
    chk({tag, "_cf"}, 32'(out_cf), 32'(cf));
    chk({tag, "_zf"}, 32'(out_zf), 32'(zf));
    chk({tag, "_nf"}, 32'(out_nf), 32'(nf));
  endtask
  task automatic push(input logic [4:0] r, input logic cf);
    in_valid = 1; in_r = r; in_cf = cf;
    step();
    in_valid = 0;
  endtask
  initial begin
    rst = 1; in_valid = 1; in_r = 5'b10101; in_cf = 1; out_ready = 0; clr_sticky = 0;
    step(); step();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_r", 32'(out_r), 0);
    chk("rst_flags", 32'({out_cf, out_zf, out_nf}), 0);
    chk("rst_sticky", 32'(sticky_cf), 0);
    rst = 0; in_valid = 0;
    chk("rst_ready", 32'(in_ready), 1);
    push(5'b01100, 1);
    head("single", 5'b01100, 1, 0, 0);
    chk("single_count", 32'(count), 1);
    chk("single_sticky", 32'(sticky_cf), 32'(STICKY));
    out_ready = 1; step(); out_ready = 0;
    chk("pop_count", 32'(count), 0);
    chk("pop_valid", 32'(out_valid), 0);
    chk("pop_r_zero", 32'(out_r), 0);
    push(5'b10000, 0);
    push(5'b00000, 1);
    chk("full_count", 32'(count), 2);
    chk("full_ready", 32'(in_ready), 0);
    push(5'b11111, 0);
    chk("full_hold_count", 32'(count), 2);
    out_ready = 1;
    head("drain0", 5'b10000, 0, 0, 1);
    step();
    head("drain1", 5'b00000, 1, 1, 0);
    chk("drain1_count", 32'(count), 1);
    step();
    chk("drain_empty", 32'(out_valid), 0);
    out_ready = 0;
    push(5'b00011, 0);
    out_ready = 1;
    push(5'b00111, 0);
    out_ready = 0;
    chk("pp_count", 32'(count), 1);
    head("pp_head", 5'b00111, 0, 0, 0);
    push(5'b01000, 0);
    chk("pp_full", 32'(count), 2);
    out_ready = 1;
    push(5'b01111, 1);
    chk("popfull_count", 32'(count), 1);
    head("popfull_head", 5'b01000, 0, 0, 0);
    step();
    out_ready = 0;
    chk("popfull_nopush", 32'(out_valid), 0);
    for (int i = 1; i <= 7; i++) begin
      push(5'(i), 0);
      chk("wrap_r", 32'(out_r), 32'(i));
      out_ready = 1; step(); out_ready = 0;
    end
    chk("wrap_empty", 32'(count), 0);
    clr_sticky = 1; step(); clr_sticky = 0;
    chk("clr_sticky", 32'(sticky_cf), 0);
    clr_sticky = 1; push(5'b00001, 1); clr_sticky = 0;
    chk("set_wins", 32'(sticky_cf), 32'(STICKY));
    clr_sticky = 1; step(); clr_sticky = 0;
    chk("lone_clr", 32'(sticky_cf), 0);
    push(5'b00010, 0);
    chk("mid_count", 32'(count), 2);
    rst = 1; step(); rst = 0;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_r", 32'(out_r), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
